// File: rtl/input_port_controller_wh_if.sv
// Wormhole input-port controller bus: FIFO pop handshake on one side,
// output-controller request/grant and flit valid/ready on the other.
interface input_port_controller_wh_if #(
  parameter int dataWidth = 32,
  parameter int NUM_PORTS = 5
) ();
  logic                 empty;
  logic                 req;
  logic                 gnt;
  logic [dataWidth-1:0] PacketIn;
  logic [NUM_PORTS-1:0] reqOutCntr;
  logic [NUM_PORTS-1:0] gntOutCntr;
  logic [dataWidth-1:0] PacketOut;
  logic                 outValid;
  logic                 outReady;
  logic                 errDrop;

  // Controller side
  modport master (
    input  empty, gnt, PacketIn, gntOutCntr, outReady,
    output req, reqOutCntr, PacketOut, outValid, errDrop
  );

  // FIFO / output-controller side
  modport slave (
    output empty, gnt, PacketIn, gntOutCntr, outReady,
    input  req, reqOutCntr, PacketOut, outValid, errDrop
  );
endinterface

// File: rtl/input_port_controller_wh.sv
// Wormhole input-port controller: pops flits from the port FIFO, routes the
// head flit XY or YX against this router's coordinates, and holds the chosen
// output connection until the tail flit has been handed over.
module input_port_controller_wh #(
  parameter int dataWidth  = 32,
  parameter int dim        = 4,
  parameter int NUM_PORTS  = 5,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int ROUTE_MODE = 0
) (
  input logic                        clk,
  input logic                        reset,
  input_port_controller_wh_if.master bus
);

  localparam int P_EAST  = 0;
  localparam int P_NORTH = 1;
  localparam int P_WEST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_LOCAL = 4;

  localparam logic [dim-1:0] L_MY_X = dim'(MY_X);
  localparam logic [dim-1:0] L_MY_Y = dim'(MY_Y);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_ROUTE,
    S_WAIT_GNT,
    S_SEND,
    S_NEXT,
    S_BODY_RD
  } state_t;

  state_t               r_state,      w_state_nxt;
  logic                 r_req,        w_req_nxt;
  logic                 r_errDrop,    w_errDrop_nxt;
  logic                 r_outValid,   w_outValid_nxt;
  logic                 r_last,       w_last_nxt;
  logic [NUM_PORTS-1:0] r_reqOutCntr, w_reqOutCntr_nxt;
  logic [dataWidth-1:0] r_PacketOut,  w_PacketOut_nxt;

  logic [NUM_PORTS-1:0] w_route;
  logic [1:0]           w_in_type;
  logic [dim-1:0]       w_dstX;
  logic [dim-1:0]       w_dstY;

  assign w_in_type = bus.PacketIn[dataWidth-1 -: 2];
  assign w_dstX    = r_PacketOut[dataWidth-3 -: dim];
  assign w_dstY    = r_PacketOut[dataWidth-3-dim -: dim];

  // Output port selection from the captured head flit (dimension-ordered)
  always_comb begin
    w_route = '0;
    if (ROUTE_MODE == 0) begin
      if      (w_dstX > L_MY_X) w_route[P_EAST]  = 1'b1;
      else if (w_dstX < L_MY_X) w_route[P_WEST]  = 1'b1;
      else if (w_dstY > L_MY_Y) w_route[P_NORTH] = 1'b1;
      else if (w_dstY < L_MY_Y) w_route[P_SOUTH] = 1'b1;
      else                      w_route[P_LOCAL] = 1'b1;
    end else begin
      if      (w_dstY > L_MY_Y) w_route[P_NORTH] = 1'b1;
      else if (w_dstY < L_MY_Y) w_route[P_SOUTH] = 1'b1;
      else if (w_dstX > L_MY_X) w_route[P_EAST]  = 1'b1;
      else if (w_dstX < L_MY_X) w_route[P_WEST]  = 1'b1;
      else                      w_route[P_LOCAL] = 1'b1;
    end
  end

  // Next-state and next registered-output values
  // r_last is decided at capture time: a head-typed flit inside an open
  // packet is treated as body, so only an explicit tail closes it there.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_nxt        = 1'b0;
    w_errDrop_nxt    = 1'b0;
    w_outValid_nxt   = r_outValid;
    w_last_nxt       = r_last;
    w_reqOutCntr_nxt = r_reqOutCntr;
    w_PacketOut_nxt  = r_PacketOut;
    unique case (r_state)
      S_IDLE: begin
        if (!bus.empty) begin
          w_req_nxt   = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (bus.gnt) begin
          w_PacketOut_nxt = bus.PacketIn;
          if (w_in_type[0]) begin
            w_last_nxt  = w_in_type[1];
            w_state_nxt = S_ROUTE;
          end else begin
            w_errDrop_nxt = 1'b1;
            w_state_nxt   = S_IDLE;
          end
        end
      end
      S_ROUTE: begin
        w_reqOutCntr_nxt = w_route;
        w_state_nxt      = S_WAIT_GNT;
      end
      S_WAIT_GNT: begin
        if ((bus.gntOutCntr & r_reqOutCntr) != '0) begin
          w_outValid_nxt = 1'b1;
          w_state_nxt    = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.outReady) begin
          w_outValid_nxt = 1'b0;
          if (r_last) begin
            w_reqOutCntr_nxt = '0;
            w_state_nxt      = S_IDLE;
          end else begin
            w_state_nxt = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        if (!bus.empty) begin
          w_req_nxt   = 1'b1;
          w_state_nxt = S_BODY_RD;
        end
      end
      S_BODY_RD: begin
        if (bus.gnt) begin
          w_PacketOut_nxt = bus.PacketIn;
          w_last_nxt      = (w_in_type == 2'b10);
          w_outValid_nxt  = 1'b1;
          w_state_nxt     = S_SEND;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any open packet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_req        <= 1'b0;
      r_errDrop    <= 1'b0;
      r_outValid   <= 1'b0;
      r_last       <= 1'b0;
      r_reqOutCntr <= '0;
      r_PacketOut  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_req        <= w_req_nxt;
      r_errDrop    <= w_errDrop_nxt;
      r_outValid   <= w_outValid_nxt;
      r_last       <= w_last_nxt;
      r_reqOutCntr <= w_reqOutCntr_nxt;
      r_PacketOut  <= w_PacketOut_nxt;
    end
  end

  assign bus.req        = r_req;
  assign bus.errDrop    = r_errDrop;
  assign bus.outValid   = r_outValid;
  assign bus.reqOutCntr = r_reqOutCntr;
  assign bus.PacketOut  = r_PacketOut;

endmodule

// File: tb/tb_input_port_controller_wh.sv
// Bench for the wormhole input-port controller: two instances at router
// (1,1), one XY and one YX, share the same FIFO and output-side stimulus.
module tb_input_port_controller_wh;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        empty = 1'b1;
  logic        gnt = 1'b0;
  logic        outReady = 1'b1;
  logic [31:0] PacketIn = '0;
  logic [4:0]  gntOutCntr = '1;

  logic [31:0] fifo_q[$];
  int          gnt_mode = 0;  // 0: grant in the req cycle, 1: one cycle later
  logic        req_d = 1'b0;
  logic        model_g;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] pkt[8];

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] exp_xy;
    logic [4:0] exp_yx;
  } rvec_t;
  rvec_t tbl[8];

  always #5 clk = ~clk;

  input_port_controller_wh_if #(.dataWidth(32), .NUM_PORTS(5)) if_xy ();
  input_port_controller_wh_if #(.dataWidth(32), .NUM_PORTS(5)) if_yx ();

  assign if_xy.empty      = empty;
  assign if_xy.gnt        = gnt;
  assign if_xy.PacketIn   = PacketIn;
  assign if_xy.gntOutCntr = gntOutCntr;
  assign if_xy.outReady   = outReady;
  assign if_yx.empty      = empty;
  assign if_yx.gnt        = gnt;
  assign if_yx.PacketIn   = PacketIn;
  assign if_yx.gntOutCntr = gntOutCntr;
  assign if_yx.outReady   = outReady;

  input_port_controller_wh #(
    .dataWidth(32), .dim(4), .NUM_PORTS(5), .MY_X(1), .MY_Y(1), .ROUTE_MODE(0)
  ) dut_xy (
    .clk(clk), .reset(reset), .bus(if_xy)
  );

  input_port_controller_wh #(
    .dataWidth(32), .dim(4), .NUM_PORTS(5), .MY_X(1), .MY_Y(1), .ROUTE_MODE(1)
  ) dut_yx (
    .clk(clk), .reset(reset), .bus(if_yx)
  );

  // FIFO model: decides grant/data for the current cycle at the falling edge
  always @(negedge clk) begin
    if (gnt_mode == 0) model_g = if_xy.req;
    else               model_g = req_d;
    req_d = if_xy.req;
    if (model_g && fifo_q.size() > 0) begin
      gnt      = 1'b1;
      PacketIn = fifo_q.pop_front();
    end else begin
      gnt = 1'b0;
    end
    empty = (fifo_q.size() == 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] x,
                                     input logic [3:0] y, input logic [21:0] pl);
    return {t, x, y, pl};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Sends pkt[0..n-1] and checks every handshake, route hold and spacing
  task automatic run_packet(input int n, input logic [4:0] exy, input logic [4:0] eyx);
    int got;
    int last;
    int cyc;
    got = 0; last = 0; cyc = 0;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) fifo_q.push_back(pkt[i]);
    while (got < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (got > 0) chk("route_held_xy", 32'(if_xy.reqOutCntr), 32'(exy));
      if (if_xy.outValid && outReady) begin
        chk("pkt_data_xy", if_xy.PacketOut, pkt[got]);
        chk("pkt_data_yx", if_yx.PacketOut, pkt[got]);
        chk("route_xy", 32'(if_xy.reqOutCntr), 32'(exy));
        chk("route_yx", 32'(if_yx.reqOutCntr), 32'(eyx));
        if (got > 0) chk("flit_spacing", 32'(cyc - last), 32'd3);
        last = cyc;
        got++;
      end
    end
    if (got < n) chk("pkt_timeout", 32'(got), 32'(n));
    @(posedge clk); #1;
    chk("route_clear_xy", 32'(if_xy.reqOutCntr), 32'd0);
    chk("route_clear_yx", 32'(if_yx.reqOutCntr), 32'd0);
    chk("valid_clear", 32'(if_xy.outValid), 32'd0);
  endtask

  initial begin
    logic [31:0] f;
    int drops;
    int vcnt;
    int rcnt;
    int cyc;
    int got;

    // Route table at router (1,1): {dstX, dstY, XY port, YX port}
    tbl[0] = '{4'd3,  4'd0, 5'b00001, 5'b01000};
    tbl[1] = '{4'd1,  4'd1, 5'b10000, 5'b10000};
    tbl[2] = '{4'd3,  4'd3, 5'b00001, 5'b00010};
    tbl[3] = '{4'd0,  4'd1, 5'b00100, 5'b00100};
    tbl[4] = '{4'd1,  4'd2, 5'b00010, 5'b00010};
    tbl[5] = '{4'd0,  4'd0, 5'b00100, 5'b01000};
    tbl[6] = '{4'd15, 4'd1, 5'b00001, 5'b00001};
    tbl[7] = '{4'd1,  4'd0, 5'b01000, 5'b01000};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",        32'(if_xy.req),        32'd0);
    chk("rst_route_xy",   32'(if_xy.reqOutCntr), 32'd0);
    chk("rst_route_yx",   32'(if_yx.reqOutCntr), 32'd0);
    chk("rst_pktout",     if_xy.PacketOut,       32'd0);
    chk("rst_valid",      32'(if_xy.outValid),   32'd0);
    chk("rst_errdrop",    32'(if_xy.errDrop),    32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Cycle-exact latency, FIFO grants one cycle after req
    gnt_mode = 1;
    f = mk(2'b11, 4'd3, 4'd0, 22'h12345);
    @(posedge clk); #1;
    fifo_q.push_back(f);
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      case (c)
        1: chk("lat_req_c1", 32'(if_xy.req), 32'd1);
        2: chk("lat_req_c2", 32'(if_xy.req), 32'd0);
        3: chk("lat_route_c3", 32'(if_xy.reqOutCntr), 32'd0);
        4: begin
          chk("lat_route_xy_c4", 32'(if_xy.reqOutCntr), 32'h01);
          chk("lat_route_yx_c4", 32'(if_yx.reqOutCntr), 32'h08);
          chk("lat_valid_c4", 32'(if_xy.outValid), 32'd0);
        end
        5: begin
          chk("lat_valid_c5", 32'(if_xy.outValid), 32'd1);
          chk("lat_data_c5", if_xy.PacketOut, f);
        end
        default: begin
          chk("lat_valid_c6", 32'(if_xy.outValid), 32'd0);
          chk("lat_route_c6", 32'(if_xy.reqOutCntr), 32'd0);
        end
      endcase
    end
    gnt_mode = 0;

    // Table-driven single-flit routing
    for (int i = 0; i < 8; i++) begin
      pkt[0] = mk(2'b11, tbl[i].x, tbl[i].y, 22'(i * 32'h1111 + 5));
      run_packet(1, tbl[i].exp_xy, tbl[i].exp_yx);
    end

    // 4-flit packet to the west
    pkt[0] = mk(2'b01, 4'd0, 4'd1, 22'h00A01);
    pkt[1] = 32'h0BAD_0001;
    pkt[2] = 32'h0BAD_0002;
    pkt[3] = 32'h8000_00F3;
    run_packet(4, 5'b00100, 5'b00100);

    // Head+tail typed flit inside an open packet travels as body
    pkt[0] = mk(2'b01, 4'd1, 4'd3, 22'h00B01);
    pkt[1] = 32'hC000_0B02;
    pkt[2] = 32'h8000_0B03;
    run_packet(3, 5'b00010, 5'b00010);

    // Unrequested grants and early outReady ignored, then backpressure
    f = mk(2'b11, 4'd3, 4'd1, 22'h2BEEF);
    gntOutCntr = 5'b11110;
    @(posedge clk); #1;
    fifo_q.push_back(f);
    cyc = 0;
    while (if_xy.reqOutCntr == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_route_xy", 32'(if_xy.reqOutCntr), 32'h01);
    chk("bp_route_yx", 32'(if_yx.reqOutCntr), 32'h01);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_wrong_gnt_no_valid", 32'(if_xy.outValid), 32'd0);
    end
    outReady   = 1'b0;
    gntOutCntr = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(if_xy.outValid), 32'd1);
      chk("bp_data_held", if_xy.PacketOut, f);
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_done", 32'(if_xy.outValid), 32'd0);
    chk("bp_route_done", 32'(if_xy.reqOutCntr), 32'd0);

    // Orphan body and tail flits
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      fifo_q.push_back(mk((k == 0) ? 2'b00 : 2'b10, 4'd2, 4'd2, 22'h0ABCD));
      drops = 0; vcnt = 0; rcnt = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (if_xy.errDrop) drops++;
        if (if_xy.outValid) vcnt++;
        if (if_xy.reqOutCntr != '0) rcnt++;
      end
      chk("orphan_drop", 32'(drops), 32'd1);
      chk("orphan_valid", 32'(vcnt), 32'd0);
      chk("orphan_route", 32'(rcnt), 32'd0);
    end

    // Reset in the middle of a 4-flit packet
    pkt[0] = mk(2'b01, 4'd0, 4'd1, 22'h00C01);
    pkt[1] = 32'h0000_0C02;
    pkt[2] = 32'h0000_0C03;
    pkt[3] = 32'h8000_0C04;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(pkt[i]);
    got = 0; cyc = 0;
    while (got < 2 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (if_xy.outValid && outReady) got++;
    end
    chk("mid_rst_pre_flits", 32'(got), 32'd2);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("mid_rst_req",      32'(if_xy.req),        32'd0);
    chk("mid_rst_route_xy", 32'(if_xy.reqOutCntr), 32'd0);
    chk("mid_rst_route_yx", 32'(if_yx.reqOutCntr), 32'd0);
    chk("mid_rst_pktout",   if_xy.PacketOut,       32'd0);
    chk("mid_rst_valid",    32'(if_xy.outValid),   32'd0);
    chk("mid_rst_errdrop",  32'(if_xy.errDrop),    32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drops = 0; vcnt = 0; rcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_xy.errDrop) drops++;
      if (if_xy.outValid) vcnt++;
      if (if_xy.reqOutCntr != '0) rcnt++;
    end
    chk("post_rst_drops", 32'(drops), 32'd2);
    chk("post_rst_valid", 32'(vcnt), 32'd0);
    chk("post_rst_route", 32'(rcnt), 32'd0);
    chk("post_rst_fifo_drained", 32'(fifo_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/input_port_controller_wh.md
Name: input_port_controller_wh

Overview:
- Parametrised wormhole input-port controller for the mesh NoC router; successor to the single-flit input controller.
- Pops flits from the port FIFO, decodes the head flit and computes an XY or YX route against this router's own coordinates.
- Requests one of NUM_PORTS output controllers and holds that connection for every flit up to and including the tail.
- Adds per-flit valid/ready flow control toward the output controller and drops orphan flits.

Parameters:
- dataWidth, 32, flit width in bits.
- dim, 4, width of each coordinate field (unsigned).
- NUM_PORTS, 5, output requests; indices East(0) North(1) West(2) South(3) Local(4); must be 5.
- MY_X, 0, this router's X coordinate.
- MY_Y, 0, this router's Y coordinate.
- ROUTE_MODE, 0, 0 = XY (X resolved first), 1 = YX.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- empty  in  1  FIFO empty flag.
- req  out  1  one-cycle pop request to the FIFO.
- gnt  in  1  FIFO grant; PacketIn is valid in the cycle gnt is high.
- PacketIn  in  dataWidth  flit from the FIFO.
- reqOutCntr  out  NUM_PORTS  one-hot request to the output controllers.
- gntOutCntr  in  NUM_PORTS  grant from the output controllers.
- PacketOut  out  dataWidth  registered flit to the output controller.
- outValid  out  1  PacketOut valid.
- outReady  in  1  output controller accepts PacketOut this cycle.
- errDrop  out  1  one-cycle pulse when an orphan flit is discarded.

Behaviour:
- Flit format:
  - [dataWidth-1:dataWidth-2] type: 00 body, 01 head, 10 tail, 11 head+tail (single-flit packet).
  - Head flit: dstX = next dim bits below type; dstY = the dim bits below dstX.
- Reset, asynchronous: req=0, reqOutCntr=0, PacketOut=0, outValid=0, errDrop=0, state=IDLE, route register=0. Reset mid-packet abandons the packet; no flit is emitted after reset deasserts until a new head arrives.
- States:
  - IDLE: if !empty, set req=1 and go to READ.
  - READ: req=0. Stay until gnt. On gnt, capture PacketIn into PacketOut.
    - Type head or head+tail: go to ROUTE.
    - Type body or tail: drop the flit, pulse errDrop, go to IDLE.
  - ROUTE (1 cycle): compute the port from the captured flit and register a one-hot reqOutCntr. Go to WAIT_GNT.
    - XY: dstX>MY_X East; dstX<MY_X West; else dstY>MY_Y North; dstY<MY_Y South; else Local.
    - YX: same comparisons with Y tested first.
  - WAIT_GNT: hold reqOutCntr. When gntOutCntr & reqOutCntr is nonzero, set outValid=1 and go to SEND.
    - Grant bits on unrequested ports are ignored.
  - SEND: hold outValid and PacketOut stable until outReady. On the outReady cycle, clear outValid.
    - Flit was tail or head+tail: clear reqOutCntr, go to IDLE.
    - Otherwise: go to NEXT.
  - NEXT: reqOutCntr stays held. If !empty, pulse req and go to BODY_RD.
  - BODY_RD: stay until gnt. On gnt, capture PacketIn, set outValid=1, go to SEND.
    - Any type is forwarded while a packet is open. A head type received mid-packet is forwarded as body.
- Latency, idle router, grant available immediately, single-flit packet:
  - Cycle 0: !empty sampled. Cycle 1: req high.
  - gnt in cycle 2, reqOutCntr in cycle 4, outValid in cycle 5.
- Body flit throughput: one flit per 3 cycles when the FIFO is non-empty and outReady is high.
- Simultaneous events:
  - gnt arriving the same cycle req is raised counts.
  - outReady during WAIT_GNT is ignored.
  - empty toggling during SEND has no effect.
- Coordinate comparisons are unsigned, dim bits wide. The header is forwarded unmodified; there is no hop increment.

Test Plan:
- MY_X=1, MY_Y=1, XY mode; single head+tail flit with dstX=3, dstY=0 -> reqOutCntr=5'b00001 (East); outValid at cycle 5 after empty falls; reqOutCntr=0 after outReady; state returns to IDLE.
- Same router, dstX=1, dstY=1 -> Local (5'b10000); with ROUTE_MODE=1, dstX=3, dstY=3 -> North (5'b00010).
- 4-flit packet (head, 2 bodies, tail) with dstX=0 -> West held for all 4 flits; reqOutCntr drops only after the tail handshake; PacketOut values match the FIFO order.
- outReady held low 10 cycles in SEND -> PacketOut and outValid stable for all 10 cycles; transfer completes on the first outReady.
- Body flit with no preceding head -> errDrop pulses once; reqOutCntr stays 0; no outValid.
- reset asserted low after the second flit of a 4-flit packet -> all outputs 0 asynchronously; after release, the leftover body/tail flits produce errDrop pulses and no forwarding.
